// File: rtl/freelist_pkg.sv
// Shared sizing constants, pointer type and port packets for the rename-stage free list.
package freelist_pkg;

  localparam int FL_SIZE        = 64;
  localparam int LOGIC_REG_SIZE = 32;
  localparam int PREG_W         = $clog2(FL_SIZE);
  localparam int PTR_W          = PREG_W + 1;
  localparam int WIDTH          = 3;

  typedef logic [PTR_W-1:0] fl_ptr_t;

  typedef struct packed {
    logic [WIDTH-1:0] alloc_req;
  } freelist_in_packet_rename_t;

  typedef struct packed {
    logic [WIDTH-1:0][PREG_W-1:0] alloc_preg;
    logic [WIDTH-1:0]             alloc_valid;
    logic                         fl_stall;
  } freelist_out_packet_t;

  typedef struct packed {
    logic [WIDTH-1:0]             retire_valid;
    logic [WIDTH-1:0][PREG_W-1:0] retire_preg;
  } freelist_in_packet_retire_t;

endpackage

// File: rtl/freelist_prefix_count.sv
// Exclusive prefix popcount and total over a 3-slot request vector (slot 0 oldest).
module freelist_prefix_count (
  input  logic [2:0] req,
  output logic [1:0] pre0,
  output logic [1:0] pre1,
  output logic [1:0] pre2,
  output logic [1:0] total
);

  // Running count of set bits below each slot.
  always_comb begin
    pre0  = 2'd0;
    pre1  = {1'b0, req[0]};
    pre2  = {1'b0, req[0]} + {1'b0, req[1]};
    total = pre2 + {1'b0, req[2]};
  end

endmodule

// File: rtl/freelist.sv
// Circular free list of physical tags: 3-wide compacted allocate at head, retire at tail,
// head restored from a branch checkpoint on recovery.
module freelist
  import freelist_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            alloc_req,
  output logic [3*PREG_W-1:0]   alloc_preg,
  output logic [2:0]            alloc_valid,
  output logic                  fl_stall,
  output logic [PTR_W-1:0]      free_count,
  input  logic [2:0]            retire_valid,
  input  logic [3*PREG_W-1:0]   retire_preg,
  output logic [PTR_W-1:0]      head_ptr_out,
  input  logic                  branch_recover,
  input  logic [PTR_W-1:0]      recover_head_ptr
);

  freelist_in_packet_rename_t ren_s;
  freelist_in_packet_retire_t ret_s;
  freelist_out_packet_t       out_s;

  logic [PREG_W-1:0] entry_r [FL_SIZE];
  fl_ptr_t           head_r;
  fl_ptr_t           tail_r;
  fl_ptr_t           head_next_s;
  fl_ptr_t           free_count_s;

  logic [1:0]        apre_s [3];
  logic [1:0]        rpre_s [3];
  logic [1:0]        alloc_total_s;
  logic [1:0]        retire_total_s;
  logic [1:0]        grant_cnt_s;
  logic [PREG_W-1:0] rd_idx_s [3];
  logic [PREG_W-1:0] wr_idx_s [3];

  assign ren_s.alloc_req    = alloc_req;
  assign ret_s.retire_valid = retire_valid;
  assign ret_s.retire_preg  = retire_preg;

  freelist_prefix_count u_alloc_pc (
    .req   (ren_s.alloc_req),
    .pre0  (apre_s[0]),
    .pre1  (apre_s[1]),
    .pre2  (apre_s[2]),
    .total (alloc_total_s)
  );

  freelist_prefix_count u_retire_pc (
    .req   (ret_s.retire_valid),
    .pre0  (rpre_s[0]),
    .pre1  (rpre_s[1]),
    .pre2  (rpre_s[2]),
    .total (retire_total_s)
  );

  assign free_count_s = tail_r - head_r;

  // Read/write indices wrap naturally because FL_SIZE is a power of two.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      rd_idx_s[k] = head_r[PREG_W-1:0] + {{(PREG_W-2){1'b0}}, apre_s[k]};
      wr_idx_s[k] = tail_r[PREG_W-1:0] + {{(PREG_W-2){1'b0}}, rpre_s[k]};
    end
  end

  // All-or-nothing grant; held off during reset and recovery.
  always_comb begin
    out_s       = '0;
    grant_cnt_s = 2'd0;
    if (!reset || branch_recover) begin
      out_s       = '0;
      grant_cnt_s = 2'd0;
    end else if ({{(PTR_W-2){1'b0}}, alloc_total_s} > free_count_s) begin
      out_s.fl_stall = 1'b1;
    end else begin
      grant_cnt_s       = alloc_total_s;
      out_s.alloc_valid = ren_s.alloc_req;
      for (int k = 0; k < 3; k++) begin
        if (ren_s.alloc_req[k]) begin
          out_s.alloc_preg[k] = entry_r[rd_idx_s[k]];
        end else begin
          out_s.alloc_preg[k] = {PREG_W{1'b0}};
        end
      end
    end
  end

  // Recovery overrides any head advance from this cycle.
  always_comb begin
    if (branch_recover) begin
      head_next_s = recover_head_ptr;
    end else begin
      head_next_s = head_r + {{(PTR_W-2){1'b0}}, grant_cnt_s};
    end
  end

  // Pointer and buffer state; retired tags are compacted at tail in slot order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r <= {PTR_W{1'b0}};
      tail_r <= PTR_W'(FL_SIZE - LOGIC_REG_SIZE);
      for (int i = 0; i < FL_SIZE; i++) begin
        entry_r[i] <= (i < FL_SIZE - LOGIC_REG_SIZE) ? PREG_W'(LOGIC_REG_SIZE + i) : {PREG_W{1'b0}};
      end
    end else begin
      head_r <= head_next_s;
      tail_r <= tail_r + {{(PTR_W-2){1'b0}}, retire_total_s};
      for (int k = 0; k < 3; k++) begin
        if (ret_s.retire_valid[k]) begin
          entry_r[wr_idx_s[k]] <= ret_s.retire_preg[k];
        end
      end
    end
  end

  assign alloc_preg   = out_s.alloc_preg;
  assign alloc_valid  = out_s.alloc_valid;
  assign fl_stall     = out_s.fl_stall;
  assign free_count   = free_count_s;
  assign head_ptr_out = head_r;

endmodule
